// File: rtl/hls_deadlock_persist_monitor.sv
// hls_deadlock_persist_monitor
// Merges AXI-Stream block flags and sub-instance idle/block flags into one raw
// stall condition. Raises a registered deadlock flag once that condition has
// persisted for THRESHOLD consecutive cycles, optionally holding it (STICKY).
// It also records the first offending source and counts detection events.
module hls_deadlock_persist_monitor #(
  parameter int NUM_AXIS  = 1,
  parameter int NUM_INST  = 1,
  parameter int THRESHOLD = 1,
  parameter int STICKY    = 0,
  parameter int CNT_W     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_AXIS-1:0]           axis_block_sigs,
  input  logic [NUM_INST-1:0]           inst_idle_sigs,
  input  logic [NUM_INST-1:0]           inst_block_sigs,
  input  logic                          clear,
  output logic                          block,
  output logic [$clog2(NUM_AXIS+1)-1:0] first_src,
  output logic                          src_valid,
  output logic [CNT_W-1:0]              event_count
);

  localparam int SRC_W = $clog2(NUM_AXIS + 1);
  localparam int PC_W  = $clog2(THRESHOLD + 1);

  // Source code NUM_AXIS stands for "the sub-instance term caused it".
  localparam logic [SRC_W-1:0] INST_SRC = SRC_W'(NUM_AXIS);

  // Persistence counter step: saturate at THRESHOLD while stalled, drop to 0
  // on any non-stalled cycle so a gap always restarts the run.
  function automatic logic [PC_W-1:0] f_pcnt_next(input logic            raw,
                                                   input logic [PC_W-1:0] cnt);
    if (!raw)
      return '0;
    else if (int'(cnt) >= THRESHOLD)
      return PC_W'(THRESHOLD);
    else
      return cnt + PC_W'(1);
  endfunction

  // True when the current stalled cycle completes a THRESHOLD-long run.
  function automatic logic f_thr_reached(input logic [PC_W-1:0] cnt);
    return (int'(cnt) + 1) >= THRESHOLD;
  endfunction

  // Saturating event counter increment; never wraps back to zero.
  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
    if (&cnt)
      return cnt;
    else
      return cnt + CNT_W'(1);
  endfunction

  // Lowest set stream index wins; with no stream bit set the sub-instance
  // term is reported instead.
  function automatic logic [SRC_W-1:0] f_first_src(input logic [NUM_AXIS-1:0] v);
    logic [SRC_W-1:0] sel;
    sel = INST_SRC;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (v[i])
        sel = SRC_W'(i);
    end
    return sel;
  endfunction

  logic              r_block;
  logic [SRC_W-1:0]  r_first_src;
  logic              r_src_valid;
  logic [CNT_W-1:0]  r_event_count;
  logic [PC_W-1:0]   r_pcnt;

  logic              w_axis_any;
  logic              w_inst_stall;
  logic              w_raw;
  logic              w_hit;
  logic              w_block_nxt;
  logic              w_rise;
  logic [SRC_W-1:0]  w_src_sel;
  logic [PC_W-1:0]   w_pcnt_nxt;

  // Every sub-instance must be stalled or idle, and at least one genuinely
  // blocked, otherwise an all-idle design would look deadlocked.
  assign w_axis_any   = |axis_block_sigs;
  assign w_inst_stall = (&(inst_block_sigs | inst_idle_sigs)) & (|inst_block_sigs);
  assign w_raw        = w_axis_any | w_inst_stall;

  assign w_hit        = w_raw & f_thr_reached(r_pcnt);
  assign w_block_nxt  = (STICKY != 0) ? (r_block | w_hit) : w_hit;
  assign w_rise       = w_block_nxt & ~r_block;
  assign w_src_sel    = f_first_src(axis_block_sigs);
  assign w_pcnt_nxt   = f_pcnt_next(w_raw, r_pcnt);

  // State update; clear behaves like reset and wins over a same-cycle hit.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_block       <= 1'b0;
      r_pcnt        <= '0;
      r_first_src   <= '0;
      r_src_valid   <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_block <= w_block_nxt;
      r_pcnt  <= w_pcnt_nxt;
      if (w_rise) begin
        r_first_src   <= w_src_sel;
        r_src_valid   <= 1'b1;
        r_event_count <= f_sat_inc(r_event_count);
      end
    end
  end

  assign block       = r_block;
  assign first_src   = r_first_src;
  assign src_valid   = r_src_valid;
  assign event_count = r_event_count;

endmodule
